// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with command-byte detection.
// Flags a capture request when the configured command byte arrives intact.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  CMD_CAPTURE  = 8'h43
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Rx,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  output logic       o_Frame_Err,
  output logic       o_Capture_Req,
  output logic       o_Busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_m;
  logic             rx_s;
  logic [1:0]       settle;
  logic             armed;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx;
      rx_s <= rx_m;
    end
  end

  // Receiver FSM; armed stays low after reset until the real line is seen
  // high, so a line held low through reset release cannot start a frame.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      settle        <= '0;
      armed         <= 1'b0;
      o_Data        <= 8'h00;
      o_Valid       <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Capture_Req <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_Valid       <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Capture_Req <= 1'b0;

      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end else if (rx_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (armed && !rx_s) begin
            state  <= START;
            o_Busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_TC) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_TC) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_TC) begin
            cnt <= '0;
            if (rx_s) begin
              o_Data        <= shift;
              o_Valid       <= 1'b1;
              o_Capture_Req <= (shift == CMD_CAPTURE);
              state         <= IDLE;
              o_Busy        <= 1'b0;
            end else begin
              o_Frame_Err <= 1'b1;
              state       <= BREAK_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: scoreboard of expected bytes, checked
// whenever the receiver pulses o_Valid.
module tb_uart_cmd_rx;

  localparam int unsigned CPB     = 16;
  localparam logic [7:0]  CMD     = 8'h43;
  localparam int          LAT_MAX = 2 + CPB / 2 + 9 * CPB + 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       i_Rx = 1'b1;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Frame_Err;
  logic       o_Capture_Req;
  logic       o_Busy;

  typedef struct packed {
    logic [7:0] data;
    logic       cap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;
  int   fe_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   v0;
  int   f0;
  logic prev_valid = 1'b0;
  logic prev_fe = 1'b0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CMD_CAPTURE(CMD)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_Rx         (i_Rx),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .o_Frame_Err  (o_Frame_Err),
    .o_Capture_Req(o_Capture_Req),
    .o_Busy       (o_Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid byte.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (o_Valid) begin
        valid_cnt++;
        chk("valid_single_cycle", 32'(prev_valid), 32'd0);
        chk("valid_latency", 32'((cyc - start_cyc) <= LAT_MAX), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(o_Data), 32'(e.data));
          chk("capture", 32'(o_Capture_Req), 32'(e.cap));
        end
      end else if (o_Capture_Req) begin
        chk("capture_without_valid", 32'(o_Valid), 32'd1);
      end
      if (o_Frame_Err) begin
        fe_cnt++;
        chk("fe_excl_valid", 32'(o_Valid), 32'd0);
        chk("fe_no_capture", 32'(o_Capture_Req), 32'd0);
        chk("fe_single_cycle", 32'(prev_fe), 32'd0);
      end
    end
    prev_valid = o_Valid;
    prev_fe    = o_Frame_Err;
  end

  task automatic hold(input logic v, input int n);
    i_Rx = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    sb.push_back(exp_t'{data: d, cap: (d == CMD)});
  endtask

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #1 Rst = 1'b1;
    #1;
    chk("rst_data", 32'(o_Data), 32'h00);
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_fe", 32'(o_Frame_Err), 32'd0);
    chk("rst_cap", 32'(o_Capture_Req), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    hold(1'b1, 20);

    // Plain byte.
    expect_byte(8'hA5);
    send(8'hA5, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("a5_data_hold", 32'(o_Data), 32'hA5);

    // Command byte.
    expect_byte(8'h43);
    send(8'h43, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("cmd_valid_cnt", 32'(valid_cnt), 32'd2);
    chk("cmd_data_hold", 32'(o_Data), 32'h43);

    // Framing error followed by a long break.
    v0 = valid_cnt;
    f0 = fe_cnt;
    send(8'h3C, 1'b0);
    hold(1'b0, 40 * CPB);
    chk("brk_busy_high", 32'(o_Busy), 32'd1);
    chk("brk_fe_cnt", 32'(fe_cnt), 32'(f0 + 1));
    chk("brk_no_valid", 32'(valid_cnt), 32'(v0));
    chk("brk_data_kept", 32'(o_Data), 32'h43);
    hold(1'b1, 6);
    chk("brk_busy_low", 32'(o_Busy), 32'd0);
    hold(1'b1, 2 * CPB);

    // Short glitch is rejected.
    v0 = valid_cnt;
    f0 = fe_cnt;
    hold(1'b0, 4);
    i_Rx = 1'b1;
    for (int i = 0; i < 12 && o_Busy; i++) @(negedge Clk);
    chk("glitch_busy_low", 32'(o_Busy), 32'd0);
    hold(1'b1, 2 * CPB);
    chk("glitch_no_valid", 32'(valid_cnt), 32'(v0));
    chk("glitch_no_fe", 32'(fe_cnt), 32'(f0));

    // Back-to-back frames with no idle time.
    v0 = valid_cnt;
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h43);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h43, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("b2b_valid_cnt", 32'(valid_cnt), 32'(v0 + 3));
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during bit 4 of 0x0F, released with the line low.
    v0 = valid_cnt;
    f0 = fe_cnt;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b0, CPB / 2);
    Rst = 1'b1;
    #2;
    chk("mid_rst_data", 32'(o_Data), 32'h00);
    chk("mid_rst_busy", 32'(o_Busy), 32'd0);
    chk("mid_rst_valid", 32'(o_Valid), 32'd0);
    chk("mid_rst_fe", 32'(o_Frame_Err), 32'd0);
    chk("mid_rst_cap", 32'(o_Capture_Req), 32'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    hold(1'b0, 12 * CPB);
    chk("low_rel_busy", 32'(o_Busy), 32'd0);
    chk("low_rel_no_valid", 32'(valid_cnt), 32'(v0));
    chk("low_rel_no_fe", 32'(fe_cnt), 32'(f0));
    hold(1'b1, 2 * CPB);
    expect_byte(8'h96);
    send(8'h96, 1'b1);
    hold(1'b1, 2 * CPB);
    chk("post_rst_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
    chk("post_rst_data", 32'(o_Data), 32'h96);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
